if_stage: RTL and testbench

- Fetch stage plus IF/ID pipeline register of the pipelined MIPS core; directly upstream of the control unit.
- Holds the PC and drives the instruction memory address.
- Selects next PC from PC+4, branch target or jump target.
- Presents instr_d / pc_plus4_d to decode; the control unit decodes instr_d[31:26] and instr_d[5:0] from it.
- Handles stall, flush and a variable-latency instruction memory.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 53 +++++
 rtl/if_stage.sv | 90 +++++++++
 tb/tb_if_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared constants and IF/ID bundle type for the pipelined MIPS core
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with stall-hold and bubble-load
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output ifid_t       ifid_o
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  // Stall holds every field; otherwise a bubble still carries the PC+4 of the slot.
  always_comb begin
    ifid_d = ifid_q;
    if (!stall_i) begin
      ifid_d.pc_plus4 = pc_plus4_i;
      if (bubble_i) begin
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
      end else begin
        ifid_d.instr = instr_i;
        ifid_d.valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc_plus4 <= 32'h0;
      ifid_q.valid    <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_o = ifid_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : fetch stage (PC register, next-PC mux) plus IF/ID register
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_d,
  input  logic [31:0] pc_branch_d,
  input  logic        jump_d,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic        w_redirect;
  logic        w_bubble;
  ifid_t       w_ifid;

  assign w_pc_plus4    = pc_q + 32'd4;
  assign w_jump_target = {w_ifid.pc_plus4[31:28], w_ifid.instr[25:0], 2'b00};
  assign w_redirect    = jump_d | pc_src_d;
  assign w_bubble      = flush_d | w_redirect | ~imem_valid | stall_f;

  // A redirect while stalled is dropped; the hazard unit re-presents it.
  always_comb begin
    pc_d = pc_q;
    if (!stall_f) begin
      if (jump_d)          pc_d = w_jump_target;
      else if (pc_src_d)   pc_d = pc_branch_d;
      else if (imem_valid) pc_d = w_pc_plus4;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!stall_d && !w_bubble) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= 32'h0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_d),
    .bubble_i   (w_bubble),
    .instr_i    (imem_rdata),
    .pc_plus4_i (w_pc_plus4),
    .ifid_o     (w_ifid)
  );

  assign imem_addr   = pc_q;
  assign pc_f        = pc_q;
  assign instr_d     = w_ifid.instr;
  assign pc_plus4_d  = w_ifid.pc_plus4;
  assign valid_d     = w_ifid.valid;
  assign fetch_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : directed stimulus, behavioural model and literal checks for if_stage
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d, pc_src_d, jump_d, imem_valid;
  logic [31:0] pc_branch_d, imem_rdata;
  logic [31:0] imem_addr, pc_f, instr_d, pc_plus4_d, fetch_count;
  logic        valid_d;

  int tests = 0;
  int fails = 0;

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_d    (pc_src_d),
    .pc_branch_d (pc_branch_d),
    .jump_d      (jump_d),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural state updated from the fetch rules.
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid;
  logic        m_init = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_instr <= NOP; m_pp4 <= 32'h0; m_valid <= 1'b0; m_cnt <= 32'h0;
      m_init <= 1'b1;
    end else begin
      if (!stall_f) begin
        if (jump_d)          m_pc <= {m_pp4[31:28], m_instr[25:0], 2'b00};
        else if (pc_src_d)   m_pc <= pc_branch_d;
        else if (imem_valid) m_pc <= m_pc + 32'd4;
      end
      if (!stall_d) begin
        m_pp4 <= m_pc + 32'd4;
        if (flush_d || jump_d || pc_src_d || !imem_valid || stall_f) begin
          m_instr <= NOP; m_valid <= 1'b0;
        end else begin
          m_instr <= imem_rdata; m_valid <= 1'b1; m_cnt <= m_cnt + 32'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model pc_f",        pc_f,        m_pc);
      chk("model imem_addr",   imem_addr,   m_pc);
      chk("model instr_d",     instr_d,     m_instr);
      chk("model pc_plus4_d",  pc_plus4_d,  m_pp4);
      chk("model valid_d",     {31'h0, valid_d}, {31'h0, m_valid});
      chk("model fetch_count", fetch_count, m_cnt);
    end
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) assert (!(stall_d && !stall_f)) else $error("stall_d without stall_f");
  end

  task automatic drive(input logic v, input logic [31:0] rd, input logic src, input logic [31:0] br,
                       input logic jmp, input logic sf, input logic sd, input logic fl);
    imem_valid = v; imem_rdata = rd; pc_src_d = src; pc_branch_d = br;
    jump_d = jmp; stall_f = sf; stall_d = sd; flush_d = fl;
    @(negedge clk);
  endtask

  task automatic lit(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                     input logic [31:0] pp4, input logic v, input logic [31:0] cnt);
    chk({tag, " pc_f"},        pc_f,        pc);
    chk({tag, " instr_d"},     instr_d,     ins);
    chk({tag, " pc_plus4_d"},  pc_plus4_d,  pp4);
    chk({tag, " valid_d"},     {31'h0, valid_d}, {31'h0, v});
    chk({tag, " fetch_count"}, fetch_count, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] words [4];
    words[0] = 32'h8C01_0000; words[1] = 32'h0022_1820;
    words[2] = 32'hAC03_0004; words[3] = 32'h1000_0003;

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("reset", 32'h0, NOP, 32'h0, 1'b0, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("seq", 32'(4 * (i + 1)), words[i], 32'(4 * (i + 1)), 1'b1, 32'(i + 1));
    end

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hBAD0_BAD0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("wait", 32'h10, NOP, 32'h14, 1'b0, 32'd4);
    end
    drive(1'b1, 32'h0109_5020, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("resume", 32'h14, 32'h0109_5020, 32'h14, 1'b1, 32'd5);

    drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("branch", 32'h40, NOP, 32'h18, 1'b0, 32'd5);
    drive(1'b1, 32'hFFFF_0000, 1'b1, 32'h1000_0004, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("branch2", 32'h1000_0004, NOP, 32'h44, 1'b0, 32'd5);
    drive(1'b1, 32'h0800_0020, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("jfetch", 32'h1000_0008, 32'h0800_0020, 32'h1000_0008, 1'b1, 32'd6);
    drive(1'b1, 32'h5555_5555, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("jump", 32'h1000_0080, NOP, 32'h1000_000C, 1'b0, 32'd6);

    drive(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("prestall", 32'h1000_0084, 32'h1234_5678, 32'h1000_0084, 1'b1, 32'd7);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0);
      lit("stall", 32'h1000_0084, 32'h1234_5678, 32'h1000_0084, 1'b1, 32'd7);
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    lit("stallf", 32'h1000_0084, NOP, 32'h1000_0088, 1'b0, 32'd7);
    drive(1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("release", 32'h1000_0088, 32'h2222_2222, 32'h1000_0088, 1'b1, 32'd8);

    drive(1'b1, 32'h2008_0005, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    lit("flush", 32'h1000_008C, NOP, 32'h1000_008C, 1'b0, 32'd8);

    drive(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap setup pc_f", pc_f, 32'hFFFF_FFFC);
    drive(1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("wrap", 32'h0, 32'h1111_1111, 32'h0, 1'b1, 32'd9);
    drive(1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("postwrap", 32'h4, 32'h3333_3333, 32'h4, 1'b1, 32'd10);

    rst_n = 1'b0;
    drive(1'b1, 32'h4444_4444, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("midreset", 32'h0, NOP, 32'h0, 1'b0, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, words[0], 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("afterreset", 32'h4, words[0], 32'h4, 1'b1, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
